// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencing controller: decodes the fetched opcode into PC
// branch/halt controls, stalls across load handshakes and parks on HALT.
module pc_seq_ctrl #(
    parameter int ADDR_W   = 9,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              zeroFlag,
    input  logic              memReady,
    input  logic              resume,
    output logic [1:0]        branchCtl,
    output logic [ADDR_W-1:0] nextAdrx,
    output logic              halt,
    output logic              memReq,
    output logic              fault,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  retired
);

    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [5:0] OP_JMP  = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_JR   = 6'h08;
    localparam logic [5:0] OP_LD   = 6'h23;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALTED   = 2'b10,
        ST_FAULT    = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          branch_ctl_q, branch_ctl_d;
    logic [ADDR_W-1:0]   next_adrx_q, next_adrx_d;
    logic                halt_q, halt_d;
    logic                mem_req_q, mem_req_d;
    logic                fault_q, fault_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic [5:0]          opcode;
    logic [ADDR_W-1:0]   target;
    logic                unused_instr_bits;

    assign opcode            = instr[31:26];
    assign target            = instr[ADDR_W-1:0];
    assign unused_instr_bits = ^instr[25:ADDR_W];

    // branchCtl defaults to 00 in every state so it can never be non-zero
    // alongside halt; the PC would otherwise let the branch win.
    always_comb begin
        state_d      = state_q;
        branch_ctl_d = 2'b00;
        next_adrx_d  = next_adrx_q;
        halt_d       = halt_q;
        mem_req_d    = mem_req_q;
        fault_d      = fault_q;
        retired_d    = retired_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            ST_RUN: begin
                halt_d    = 1'b0;
                mem_req_d = 1'b0;
                retired_d = retired_q + CNT_W'(1);
                case (opcode)
                    OP_JMP: begin
                        branch_ctl_d = 2'b10;
                        next_adrx_d  = target;
                    end
                    OP_BEQ: begin
                        branch_ctl_d = zeroFlag ? 2'b01 : 2'b00;
                        next_adrx_d  = target;
                    end
                    OP_BNE: begin
                        branch_ctl_d = zeroFlag ? 2'b00 : 2'b01;
                        next_adrx_d  = target;
                    end
                    OP_JR: begin
                        branch_ctl_d = 2'b11;
                    end
                    OP_LD: begin
                        mem_req_d  = 1'b1;
                        halt_d     = 1'b1;
                        wait_cnt_d = '0;
                        retired_d  = retired_q;
                        state_d    = ST_MEM_WAIT;
                    end
                    OP_HALT: begin
                        halt_d  = 1'b1;
                        state_d = ST_HALTED;
                    end
                    default: ;
                endcase
            end
            ST_MEM_WAIT: begin
                halt_d = 1'b1;
                if (memReady) begin
                    mem_req_d = 1'b0;
                    halt_d    = 1'b0;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = ST_RUN;
                end else if (wait_cnt_q == WAIT_W'(WAIT_MAX - 1)) begin
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_HALTED: begin
                halt_d    = 1'b1;
                mem_req_d = 1'b0;
                if (resume) begin
                    halt_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                halt_d    = 1'b1;
                fault_d   = 1'b1;
                mem_req_d = 1'b0;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            branch_ctl_q <= 2'b00;
            next_adrx_q  <= '0;
            halt_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            fault_q      <= 1'b0;
            retired_q    <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            branch_ctl_q <= branch_ctl_d;
            next_adrx_q  <= next_adrx_d;
            halt_q       <= halt_d;
            mem_req_q    <= mem_req_d;
            fault_q      <= fault_d;
            retired_q    <= retired_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign branchCtl = branch_ctl_q;
    assign nextAdrx  = next_adrx_q;
    assign halt      = halt_q;
    assign memReq    = mem_req_q;
    assign fault     = fault_q;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Sequencing controller for the CPU program counter.
- Decodes the fetched instruction's control field and the ALU zero flag, then drives the PC's branch select, branch target and halt inputs.
- Stalls the PC across multi-cycle memory loads using a request/ready handshake, and parks the CPU on HALT until resumed.
- Sits between instruction memory, the ALU flags, the data memory interface and the PC register.

Parameters:
- ADDR_W, 9, width of the PC and of branch targets.
- WAIT_MAX, 15, maximum cycles to wait for memReady before faulting.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- instr  input  32  fetched instruction; opcode is instr[31:26], target is instr[ADDR_W-1:0].
- zeroFlag  input  1  ALU zero result for the current instruction.
- memReady  input  1  data memory has completed the outstanding load.
- resume  input  1  one-cycle pulse releasing the HALTED state.
- branchCtl  output  2  to PC: 00 sequential, 01 conditional branch taken, 10 jump, 11 jump-register.
- nextAdrx  output  ADDR_W  to PC: absolute branch/jump target.
- halt  output  1  to PC: hold the current count.
- memReq  output  1  load request to data memory; held high until the handshake completes.
- fault  output  1  sticky memory-timeout indicator.
- state  output  2  current FSM state, for debug.
- retired  output  CNT_W  count of retired instructions.

Behaviour:
- All outputs are registered on posedge clk. The PC samples them at the following negedge (half-cycle latency).
- Reset (rst=1 at posedge, any state, including mid-wait) forces:
  - state=RUN, branchCtl=00, nextAdrx=0, halt=0;
  - memReq=0, fault=0, retired=0, wait counter=0.
- Opcodes:
  - NOP 0x00
  - JMP 0x02
  - BEQ 0x04
  - BNE 0x05
  - JR 0x08
  - LD 0x23
  - HALT 0x3F
  - All others decode as NOP.
- States: RUN=00, MEM_WAIT=01, HALTED=10, FAULT=11.
- RUN, one instruction per cycle:
  - JMP: branchCtl=10, nextAdrx=target.
  - BEQ: branchCtl=01 if zeroFlag=1, else 00. nextAdrx=target regardless.
  - BNE: branchCtl=01 if zeroFlag=0, else 00. nextAdrx=target regardless.
  - JR: branchCtl=11 (PC takes its register-file operand).
  - LD: memReq=1, halt=1, branchCtl=00, wait counter=0, go to MEM_WAIT. Not retired yet.
  - HALT: halt=1, branchCtl=00, go to HALTED. Retired.
  - NOP/other: branchCtl=00, halt=0.
  - Every non-LD opcode increments retired.
- MEM_WAIT:
  - instr and zeroFlag are ignored; branchCtl=00; halt=1.
  - If memReady=1: memReq=0, halt=0, retired+1, go to RUN. The PC advances by 4 on the next negedge.
  - Else if wait counter==WAIT_MAX-1: memReq=0, fault=1, halt=1, go to FAULT.
  - Else wait counter+1.
  - memReady asserted in the same cycle LD is decoded is ignored; the handshake begins the cycle after memReq rises.
- HALTED:
  - halt=1, branchCtl=00, memReq=0.
  - resume=1: halt=0, go to RUN. The PC advances past HALT.
  - resume while in RUN or MEM_WAIT is ignored.
- FAULT:
  - Absorbing; halt=1, fault=1, branchCtl=00.
  - Only rst exits.
- retired wraps modulo 2^CNT_W and does not saturate.
- branchCtl is never non-zero while halt=1. This is required because the PC gives branches priority over halt.
- Targets wider than ADDR_W are truncated to instr[ADDR_W-1:0]; no range check.

Test Plan:
- Reset mid-wait: issue LD, hold memReady=0 for 3 cycles, pulse rst. Expect state=00, memReq=0, halt=0, retired=0 on the next posedge, and PC at 0.
- Branch decode: BEQ with target 0x040 and zeroFlag=1 gives branchCtl=01, nextAdrx=0x040, PC=0x040. BNE with the same flag gives branchCtl=00 and the PC advances by 4. JR gives branchCtl=11.
- Load handshake: LD at PC=0x010, memReady=1 after 4 cycles. Expect:
  - halt=1 and memReq=1 for exactly 4 cycles;
  - then PC=0x014 and retired increments once.
- Timeout: LD with memReady held at 0. Expect fault=1 and state=11 after WAIT_MAX=15 wait cycles; the PC stays frozen through 20 further cycles.
- Halt/resume: HALT at PC=0x020. PC holds at 0x020 for 10 cycles, with a stray JMP presented on instr and branchCtl staying 00. Pulse resume; expect PC=0x024.
- Counter wrap: run with CNT_W=4 and 17 NOPs. Expect retired=1.
